// File: rtl/ints2float.sv
// Integer-to-binary32 converter for FCVT.S.W / FCVT.S.WU.
// An iterative byte/bit normaliser feeds a single rounding step; one operation is in flight at a time.
module ints2float (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] int_in,
    input  logic        is_signed,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        fflag_nx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [7:0] EXP_TOP = 8'd158;  // biased exponent of a value with bit 31 set

    state_t      state;
    logic [31:0] mag;
    logic [7:0]  exp;
    logic        sign;
    logic        op_signed;
    logic [2:0]  rm_q;
    logic [31:0] result_q;
    logic        nx_q;

    logic        negate;
    logic        lsb;
    logic        guard;
    logic        sticky;
    logic        inexact;
    logic        round_up;
    logic [30:0] rounded;

    // The operand is captured raw; its sign is only resolved in ABS.
    assign negate = op_signed & mag[31];

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        lsb      = mag[8];
        guard    = mag[7];
        sticky   = |mag[6:0];
        inexact  = guard | sticky;
        round_up = 1'b0;
        case (rm_q)
            RM_RNE:  round_up = guard & (sticky | lsb);
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = inexact & sign;
            RM_RUP:  round_up = inexact & ~sign;
            RM_RMM:  round_up = guard;
            default: round_up = guard & (sticky | lsb);
        endcase
        // A mantissa carry ripples straight into the exponent field.
        rounded = {exp, mag[30:8]} + {30'd0, round_up};
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mag       <= 32'd0;
            exp       <= 8'd0;
            sign      <= 1'b0;
            op_signed <= 1'b0;
            rm_q      <= 3'd0;
            result_q  <= 32'd0;
            nx_q      <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag       <= int_in;
                        op_signed <= is_signed;
                        rm_q      <= rm;
                        state     <= ABS;
                    end
                end
                ABS: begin
                    sign <= negate;
                    mag  <= negate ? (~mag + 32'd1) : mag;
                    exp  <= EXP_TOP;
                    if (mag == 32'd0) begin
                        result_q <= 32'd0;
                        nx_q     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag[31]) begin
                        state <= ROUND;
                    end else if (mag[31:24] == 8'd0) begin
                        mag <= {mag[23:0], 8'd0};
                        exp <= exp - 8'd8;
                    end else begin
                        mag <= {mag[30:0], 1'b0};
                        exp <= exp - 8'd1;
                    end
                end
                ROUND: begin
                    result_q <= {sign, rounded};
                    nx_q     <= inexact;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign fflag_nx  = nx_q;

endmodule

// File: tb/tb_ints2float.sv
// Directed bench for ints2float: a queue of expected results is filled at acceptance
// and drained when the converter presents each result.
module tb_ints2float;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_in;
    logic        is_signed;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        fflag_nx;

    typedef struct {
        logic [31:0] res;
        logic        nx;
        int          lat;
    } expect_t;

    expect_t     sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] held;

    ints2float dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .int_in    (int_in),
        .is_signed (is_signed),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .fflag_nx  (fflag_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Cycles from acceptance to out_valid: 1 for zero, else floor(lz/8) + lz%8 + 3.
    function automatic int exp_latency(input logic [31:0] v, input logic s);
        logic [31:0] m;
        int          lz;
        m = (s && v[31]) ? (~v + 32'd1) : v;
        if (m == 32'd0) return 1;
        lz = 0;
        while (!m[31 - lz]) lz++;
        return lz / 8 + lz % 8 + 3;
    endfunction

    // Reference conversion: locate the leading one, then round the dropped bits.
    function automatic expect_t model(input logic [31:0] v, input logic s, input logic [2:0] mode);
        expect_t     e;
        logic        sg;
        logic [31:0] m;
        logic [31:0] n;
        logic [31:0] f;
        logic [7:0]  be;
        logic        g;
        logic        st;
        logic        up;
        int          p;
        sg = s & v[31];
        m  = sg ? (~v + 32'd1) : v;
        e.lat = exp_latency(v, s);
        if (m == 32'd0) begin
            e.res = 32'd0;
            e.nx  = 1'b0;
            return e;
        end
        p = 31;
        while (!m[p]) p--;
        n  = m << (31 - p);
        be = 8'(127 + p);
        g  = n[7];
        st = |n[6:0];
        case (mode)
            3'b001:  up = 1'b0;
            3'b010:  up = (g | st) & sg;
            3'b011:  up = (g | st) & ~sg;
            3'b100:  up = g;
            default: up = g & (st | n[8]);
        endcase
        f     = {1'b0, be, n[30:8]} + {31'd0, up};
        f[31] = sg;
        e.res = f;
        e.nx  = g | st;
        return e;
    endfunction

    task automatic start_op(input logic [31:0] v, input logic s, input logic [2:0] mode,
                            input logic [31:0] exp_res, input logic exp_nx);
        expect_t e;
        in_valid  = 1'b1;
        int_in    = v;
        is_signed = s;
        rm        = mode;
        @(posedge clk); #1;
        in_valid = 1'b0;
        int_in   = 32'hDEAD_BEEF;
        e.res = exp_res;
        e.nx  = exp_nx;
        e.lat = exp_latency(v, s);
        sb.push_back(e);
    endtask

    task automatic start_model(input logic [31:0] v, input logic s, input logic [2:0] mode);
        expect_t e;
        e = model(v, s, mode);
        start_op(v, s, mode, e.res, e.nx);
    endtask

    task automatic wait_result(input string tag);
        expect_t e;
        int      lat;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_lat"}, lat, e.lat);
            check({tag, "_res"}, result, e.res);
            check({tag, "_nx"}, 32'(fflag_nx), 32'(e.nx));
        end
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        held = result;
    endtask

    task automatic finish_op(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_res"}, result, held);
            check({tag, "_hold_ctl"}, {30'd0, out_valid, in_ready}, 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int   seen;
        logic [31:0] v;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        int_in    = 32'd0;
        is_signed = 1'b0;
        rm        = 3'd0;
        out_ready = 1'b0;
        #12;
        check("reset_ctl", {30'd0, out_valid, in_ready}, 32'b01);
        check("reset_res", result, 32'd0);
        check("reset_nx", 32'(fflag_nx), 32'd0);
        #11 reset_n = 1'b1;
        @(posedge clk); #1;

        start_op(32'd1, 1'b1, 3'b000, 32'h3F80_0000, 1'b0);          wait_result("one");      finish_op("one", 0);
        start_op(32'hFFFF_FFFF, 1'b1, 3'b000, 32'hBF80_0000, 1'b0);  wait_result("minus1");   finish_op("minus1", 0);
        start_op(32'd0, 1'b1, 3'b000, 32'h0000_0000, 1'b0);          wait_result("zero");     finish_op("zero", 0);
        start_op(32'h8000_0000, 1'b1, 3'b000, 32'hCF00_0000, 1'b0);  wait_result("intmin");   finish_op("intmin", 0);
        start_op(32'hFFFF_FFFF, 1'b0, 3'b000, 32'h4F80_0000, 1'b1);  wait_result("umax_rne"); finish_op("umax_rne", 0);
        start_op(32'hFFFF_FFFF, 1'b0, 3'b001, 32'h4F7F_FFFF, 1'b1);  wait_result("umax_rtz"); finish_op("umax_rtz", 0);
        start_op(32'h0100_0001, 1'b1, 3'b000, 32'h4B80_0000, 1'b1);  wait_result("tie_rne");  finish_op("tie_rne", 0);
        start_op(32'h0100_0001, 1'b1, 3'b011, 32'h4B80_0001, 1'b1);  wait_result("tie_rup");  finish_op("tie_rup", 0);
        start_op(32'h0100_0001, 1'b1, 3'b100, 32'h4B80_0001, 1'b1);  wait_result("tie_rmm");  finish_op("tie_rmm", 0);
        start_op(32'h0100_0001, 1'b1, 3'b010, 32'h4B80_0000, 1'b1);  wait_result("tie_rdn");  finish_op("tie_rdn", 0);
        start_op(32'hFEFF_FFFF, 1'b1, 3'b010, 32'hCB80_0001, 1'b1);  wait_result("neg_rdn");  finish_op("neg_rdn", 0);
        start_op(32'hFEFF_FFFF, 1'b1, 3'b011, 32'hCB80_0000, 1'b1);  wait_result("neg_rup");  finish_op("neg_rup", 0);
        start_op(32'h0100_0003, 1'b0, 3'b111, 32'h4B80_0002, 1'b1);  wait_result("rm7_rne");  finish_op("rm7_rne", 0);

        // Consumer stalls for five cycles after the result appears.
        start_model(32'd1000, 1'b1, 3'b000);
        wait_result("stall");
        finish_op("stall", 5);

        // out_ready raised before the result exists.
        out_ready = 1'b1;
        start_model(32'h0012_3457, 1'b0, 3'b011);
        wait_result("early_rdy");
        finish_op("early_rdy", 0);

        for (int i = 0; i < 6; i++) begin
            v = $urandom() >> $urandom_range(31, 0);
            start_model(v, i[0], 3'($urandom_range(7, 0)));
            wait_result("rand");
            finish_op("rand", 0);
        end

        // flush in IDLE with in_valid high must not accept.
        in_valid = 1'b1;
        int_in   = 32'd5;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle", {30'd0, out_valid, in_ready}, 32'b01);

        // flush while normalising.
        start_model(32'd1, 1'b0, 3'b000);
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(sb.pop_back());
        check("flush_norm", {30'd0, out_valid, in_ready}, 32'b01);
        seen = 0;
        repeat (15) begin @(posedge clk); #1; seen += int'(out_valid); end
        check("flush_norm_quiet", seen, 0);
        start_model(32'h7FFF_FFFF, 1'b1, 3'b000); wait_result("after_flush"); finish_op("after_flush", 0);

        // flush while the result is waiting.
        start_model(32'd77, 1'b1, 3'b000);
        wait_result("flush_done");
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done_drop", {30'd0, out_valid, in_ready}, 32'b01);

        // Asynchronous reset mid-normalisation.
        start_model(32'd3, 1'b0, 3'b000);
        repeat (3) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("areset_ctl", {30'd0, out_valid, in_ready}, 32'b01);
        check("areset_res", result, 32'd0);
        check("areset_nx", 32'(fflag_nx), 32'd0);
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
        start_model(32'hFFFF_FF85, 1'b1, 3'b010); wait_result("after_reset"); finish_op("after_reset", 0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
